// File: rtl/seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_capture
//  Purpose  : Receive-side monitor for a multiplexed four-digit seven-segment
//             bus. Waits for each active-low anode strobe and segment pattern
//             to settle, decodes the lit pattern back to a hex digit and
//             publishes a frame-consistent 16-bit value once every digit
//             position has been captured.
//
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous reset, active low
//             seg_L      - active-low segments, bit 6 = a ... bit 0 = g
//             anode_L    - active-low digit strobes, bit 3 = leftmost digit
//             value      - last complete frame, value[15:12] = leftmost digit
//             blank      - last complete frame, bit i = digit i was all-off
//             frame_done - one-cycle pulse when value/blank update
//             err        - one-cycle pulse on illegal pattern or multi strobe
//
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_capture #(
    parameter int SETTLE = 4    // stable cycles required before capture, 1..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_L,
    input  logic [3:0]  anode_L,
    output logic [15:0] value,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        err
);

    localparam logic [7:0] c_settle    = 8'(SETTLE);
    localparam logic [7:0] c_settle_m1 = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [6:0]       r_seg;
    logic [3:0]       r_an;
    logic [7:0]       r_cnt;
    state_t           r_state;
    logic [3:0][3:0]  r_slot;
    logic [3:0]       r_blank_slot;
    logic [3:0]       r_seen;
    logic             r_multi_q;
    logic [15:0]      r_value;
    logic [3:0]       r_blank;
    logic             r_frame_done;
    logic             r_err;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic             w_chg;
    logic             w_an_onehot;
    logic             w_an_idle;
    logic             w_an_multi;
    logic [1:0]       w_slot_idx;
    logic [3:0]       w_dec_digit;
    logic             w_dec_legal;
    logic             w_dec_blank;
    state_t           w_state_nxt;
    logic             w_capture;
    logic             w_cnt_ready;
    logic [3:0][3:0]  w_slot_upd;
    logic [3:0]       w_blank_upd;
    logic [3:0]       w_seen_upd;
    logic             w_capture_ok;
    logic             w_frame_complete;
    logic             w_multi_err;

    // The input registers update on this edge whenever the live bus differs
    // from them, so this is exactly "the registered copy is changing now".
    // Clearing the counter on the same edge gives capture on edge t+1+SETTLE
    // for a bus change at edge t.
    assign w_chg = (seg_L != r_seg) || (anode_L != r_an);

    assign w_cnt_ready = (r_cnt == c_settle_m1) && !w_chg;

    // ------------------------------------------------------------------------
    // Anode classification and slot index
    // ------------------------------------------------------------------------
    always_comb begin
        w_an_onehot = 1'b1;
        w_slot_idx  = 2'd0;
        case (r_an)
            4'b1110: w_slot_idx = 2'd0;
            4'b1101: w_slot_idx = 2'd1;
            4'b1011: w_slot_idx = 2'd2;
            4'b0111: w_slot_idx = 2'd3;
            default: w_an_onehot = 1'b0;
        endcase
    end

    assign w_an_idle  = (r_an == 4'b1111);
    assign w_an_multi = !w_an_onehot && !w_an_idle;

    // ------------------------------------------------------------------------
    // Segment decode (active-low pattern, a..g = bit 6..0)
    // ------------------------------------------------------------------------
    always_comb begin
        w_dec_digit = 4'h0;
        w_dec_legal = 1'b1;
        w_dec_blank = 1'b0;
        case (r_seg)
            7'h01: w_dec_digit = 4'h0;
            7'h4F: w_dec_digit = 4'h1;
            7'h12: w_dec_digit = 4'h2;
            7'h06: w_dec_digit = 4'h3;
            7'h4C: w_dec_digit = 4'h4;
            7'h24: w_dec_digit = 4'h5;
            7'h20: w_dec_digit = 4'h6;
            7'h0F: w_dec_digit = 4'h7;
            7'h00: w_dec_digit = 4'h8;
            7'h04: w_dec_digit = 4'h9;
            7'h08: w_dec_digit = 4'hA;
            7'h60: w_dec_digit = 4'hB;
            7'h31: w_dec_digit = 4'hC;
            7'h42: w_dec_digit = 4'hD;
            7'h30: w_dec_digit = 4'hE;
            7'h38: w_dec_digit = 4'hF;
            7'h7F: w_dec_blank = 1'b1;
            default: w_dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM next state and capture strobe
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_an_onehot) begin
                    // With SETTLE=1 the strobe can already be settled on the
                    // first cycle it is visible in the registered copy.
                    if (w_cnt_ready) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_an_onehot) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // A change re-enters SETTLE; if the new strobe is not one-hot
                // SETTLE drops to IDLE as soon as it is registered.
                if (!w_an_onehot) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_chg) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Slot update preview: the frame load must include the digit captured on
    // the completing edge, so the updated slot set is formed combinationally.
    // ------------------------------------------------------------------------
    always_comb begin
        w_slot_upd              = r_slot;
        w_blank_upd             = r_blank_slot;
        w_slot_upd[w_slot_idx]  = w_dec_digit;
        w_blank_upd[w_slot_idx] = w_dec_blank;
    end

    assign w_seen_upd       = r_seen | (4'b0001 << w_slot_idx);
    assign w_capture_ok     = w_capture && w_dec_legal;
    assign w_frame_complete = w_capture_ok && (w_seen_upd == 4'b1111);

    // One error per multi-strobe occurrence: flag only the first cycle.
    assign w_multi_err = w_an_multi && !r_multi_q;

    // ------------------------------------------------------------------------
    // Input registers and stability counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seg <= 7'h7F;
            r_an  <= 4'hF;
            r_cnt <= 8'd0;
        end else begin
            r_seg <= seg_L;
            r_an  <= anode_L;
            if (w_chg) begin
                r_cnt <= 8'd0;
            end else if (r_cnt != c_settle) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Slot storage, frame assembly and output pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot       <= '0;
            r_blank_slot <= 4'h0;
            r_seen       <= 4'h0;
            r_multi_q    <= 1'b0;
            r_value      <= 16'h0000;
            r_blank      <= 4'hF;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_multi_q    <= w_an_multi;
            r_frame_done <= w_frame_complete;
            r_err        <= w_multi_err || (w_capture && !w_dec_legal);

            if (w_capture_ok) begin
                r_slot       <= w_slot_upd;
                r_blank_slot <= w_blank_upd;
                if (w_frame_complete) begin
                    r_value <= w_slot_upd;
                    r_blank <= w_blank_upd;
                    r_seen  <= 4'h0;
                end else begin
                    r_seen  <= w_seen_upd;
                end
            end
        end
    end

    assign value      = r_value;
    assign blank      = r_blank;
    assign frame_done = r_frame_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_capture
//  Purpose  : Self-checking bench for seg7_capture. Expected frames (value,
//             blank, completion cycle) are queued as stimulus is driven and
//             compared when the DUT pulses frame_done; error pulses are
//             counted against an expected tally.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_capture;

    localparam int SETTLE = 4;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic [6:0]  seg_L   = 7'h7F;
    logic [3:0]  anode_L = 4'hF;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        frame_done;
    logic        err;

    seg7_capture #(
        .SETTLE(SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_L      (seg_L),
        .anode_L    (anode_L),
        .value      (value),
        .blank      (blank),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] value;
        logic [3:0]  blank;
        int          cyc;
    } frame_t;

    frame_t exp_q[$];

    int checks      = 0;
    int failures    = 0;
    int frames_seen = 0;
    int err_seen    = 0;
    int err_exp     = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive a bus pattern and hold it for n sampling edges.
    task automatic drive(input logic [3:0] an, input logic [6:0] code, input int n);
        anode_L = an;
        seg_L   = code;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call immediately before driving the digit that completes a frame.
    task automatic push_frame(input logic [15:0] v, input logic [3:0] b);
        frame_t f;
        f.value = v;
        f.blank = b;
        f.cyc   = cyc + 1 + SETTLE;
        exp_q.push_back(f);
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_done) begin
            frames_seen++;
            check_eq("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                frame_t e;
                e = exp_q.pop_front();
                check_eq("frame_value", 32'(value), 32'(e.value));
                check_eq("frame_blank", 32'(blank), 32'(e.blank));
                check_eq("frame_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (err) err_seen++;
        if (err || frame_done) check_eq("err_fd_exclusive", 32'(err & frame_done), 32'd0);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        check_eq("rst_value", 32'(value), 32'h0000);
        check_eq("rst_blank", 32'(blank), 32'hF);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // ---------------- ideal scan: 2345 ----------------
        drive(4'b0111, 7'h12, 8);
        drive(4'b1011, 7'h06, 8);
        drive(4'b1101, 7'h4C, 8);
        push_frame(16'h2345, 4'b0000);
        drive(4'b1110, 7'h24, 8);
        drive(4'b1111, 7'h7F, 4);
        check_eq("scan_frames", 32'(frames_seen), 32'd1);

        // ---------------- glitch, multi strobe, blank + letters ----------------
        drive(4'b1110, 7'h01, SETTLE);   // too short to capture
        drive(4'b1111, 7'h7F, 6);
        drive(4'b0111, 7'h7F, 8);
        drive(4'b1011, 7'h08, 8);
        err_exp++;
        drive(4'b1100, 7'h7F, 10);       // multi strobe
        drive(4'b1111, 7'h7F, 2);
        drive(4'b1101, 7'h60, 8);
        check_eq("glitch_no_frame", 32'(frames_seen), 32'd1);
        check_eq("value_stable", 32'(value), 32'h2345);
        push_frame(16'h0ABF, 4'b1000);
        drive(4'b1110, 7'h38, 8);
        drive(4'b1111, 7'h7F, 4);
        check_eq("letters_frames", 32'(frames_seen), 32'd2);
        check_eq("multi_err_count", 32'(err_seen), 32'(err_exp));

        // ---------------- illegal code, scroll on digit 0 ----------------
        drive(4'b0111, 7'h06, 8);
        drive(4'b1011, 7'h12, 8);
        err_exp++;
        drive(4'b1101, 7'h55, 10);       // illegal under slot 1
        drive(4'b1110, 7'h31, 8);
        drive(4'b1110, 7'h42, 8);        // scroll: new code, same anode
        drive(4'b1111, 7'h7F, 2);
        check_eq("illegal_not_seen", 32'(frames_seen), 32'd2);
        check_eq("illegal_err_count", 32'(err_seen), 32'(err_exp));
        push_frame(16'h321D, 4'b0000);
        drive(4'b1101, 7'h4F, 8);
        drive(4'b1111, 7'h7F, 4);
        check_eq("scroll_frames", 32'(frames_seen), 32'd3);

        // ---------------- reset mid-frame ----------------
        drive(4'b0111, 7'h24, 8);
        drive(4'b1011, 7'h20, 8);
        anode_L = 4'hF;
        seg_L   = 7'h7F;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_eq("midrst_value", 32'(value), 32'h0000);
        check_eq("midrst_blank", 32'(blank), 32'hF);
        drive(4'b1101, 7'h0F, SETTLE + 1);   // shortest hold that captures
        drive(4'b1110, 7'h00, SETTLE + 1);
        drive(4'b1111, 7'h7F, 2);
        check_eq("midrst_no_frame", 32'(frames_seen), 32'd3);
        check_eq("midrst_value_hold", 32'(value), 32'h0000);
        check_eq("midrst_blank_hold", 32'(blank), 32'hF);
        drive(4'b0111, 7'h01, 8);
        push_frame(16'h0178, 4'b0000);
        drive(4'b1011, 7'h4F, 8);
        drive(4'b1111, 7'h7F, 4);
        check_eq("final_frames", 32'(frames_seen), 32'd4);
        check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check_eq("final_err_count", 32'(err_seen), 32'(err_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
